alu_pipe: RTL and testbench

//   Parametrised, pipelined ALU for the TP1 datapath. Successor to the single-register ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_pipe.sv | 88 ++++++++
 tb/tb_alu_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the TP1 pipelined ALU.
//   N_OP      opcode width (MIPS funct field)
//   OP_*      legal opcodes
//   flags_t   status flags, bus order {err, ovf, carry, neg, zero}
package alu_pkg;

  localparam int N_OP    = 6;
  localparam int N_FLAGS = 5;

  localparam logic [N_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [N_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [N_OP-1:0] OP_AND = 6'b100100;
  localparam logic [N_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [N_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [N_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [N_OP-1:0] OP_SLT = 6'b101010;
  localparam logic [N_OP-1:0] OP_SLL = 6'b000000;
  localparam logic [N_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [N_OP-1:0] OP_SRA = 6'b000011;

  typedef struct packed {
    logic err;
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath, sits between S1 and S2.
//   a, b    operands (b is the shift amount for SLL/SRL/SRA)
//   op      opcode
//   result  N_BITS result, truncated
//   flags   {err, ovf, carry, neg, zero}
module alu_core import alu_pkg::*; #(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0]  a,
  input  logic [N_BITS-1:0]  b,
  input  logic [N_OP-1:0]    op,
  output logic [N_BITS-1:0]  result,
  output logic [N_FLAGS-1:0] flags
);

  localparam int MSB = N_BITS - 1;

  logic [N_BITS:0]          sum, diff;
  logic signed [N_BITS-1:0] sra;
  logic                     big;
  logic [N_BITS-1:0]        res;
  flags_t                   f;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // diff[N_BITS] is the borrow: set exactly when a < b unsigned
    diff = {1'b0, a} - {1'b0, b};
    // computed on its own so the arithmetic shift is not turned logical by
    // an unsigned operand elsewhere in the expression
    sra  = $signed(a) >>> b;
    big  = 32'(b) >= N_BITS;
    res  = '0;
    f    = '0;
    case (op)
      OP_ADD: begin
        res     = sum[MSB:0];
        f.carry = sum[N_BITS];
        f.ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res     = diff[MSB:0];
        f.carry = diff[N_BITS];
        f.ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SLT: res[0] = $signed(a) < $signed(b);
      OP_SLL: res = big ? '0 : (a << b);
      OP_SRL: res = big ? '0 : (a >> b);
      OP_SRA: res = big ? {N_BITS{a[MSB]}} : sra;
      default: f.err = 1'b1;
    endcase
    f.zero = (res == '0);
    f.neg  = res[MSB];
    result = res;
    flags  = f;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
//   clock, reset (async, active low)
//   i_valid/o_ready/i_a/i_b/i_op    upstream operation
//   o_valid/i_ready/o_result        downstream result
//   o_zero/o_neg/o_carry/o_ovf/o_err status flags of the result
// S1 holds {op, a, b}; S2 holds {result, flags}. o_ready is combinational
// from i_ready, so a full pipe accepts a new op in the same cycle the sink
// drains the oldest one.
module alu_pipe #(
  parameter int N_BITS = 8,
  parameter int N_OP   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  input  logic [N_OP-1:0]   i_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [N_BITS-1:0] o_result,
  output logic              o_zero,
  output logic              o_neg,
  output logic              o_carry,
  output logic              o_ovf,
  output logic              o_err
);
  import alu_pkg::*;

  // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid
  logic [2:1]           vld_pipe;
  logic [N_OP-1:0]      s1_op;
  logic [N_BITS-1:0]    s1_a, s1_b;
  logic [N_BITS-1:0]    s2_res, core_res;
  logic [N_FLAGS-1:0]   s2_flags, core_flags;
  logic                 s2_en;
  flags_t               fl;

  assign s2_en   = !vld_pipe[2] || i_ready;
  assign o_ready = !vld_pipe[1] || s2_en;

  alu_core #(.N_BITS(N_BITS)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_res),
    .flags  (core_flags)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else begin
      if (o_ready) begin
        vld_pipe[1] <= i_valid;
        if (i_valid) begin
          s1_op <= i_op;
          s1_a  <= i_a;
          s1_b  <= i_b;
        end
      end
      if (s2_en) begin
        vld_pipe[2] <= vld_pipe[1];
        // only load on a real op so an idle S2 keeps its last value
        if (vld_pipe[1]) begin
          s2_res   <= core_res;
          s2_flags <= core_flags;
        end
      end
    end
  end

  assign fl       = flags_t'(s2_flags);
  assign o_valid  = vld_pipe[2];
  assign o_result = s2_res;
  assign o_zero   = fl.zero;
  assign o_neg    = fl.neg;
  assign o_carry  = fl.carry;
  assign o_ovf    = fl.ovf;
  assign o_err    = fl.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (N_BITS=8).
// Reference: integer-arithmetic ALU model plus an in-order queue of
// expected results, treating the pipe as a capacity-2 FIFO whose entries
// become visible two cycles after they are presented.
module tb_alu_pipe;

  logic       clock, reset;
  logic       i_valid, o_ready, o_valid, i_ready;
  logic [7:0] i_a, i_b, o_result;
  logic [5:0] i_op;
  logic       o_zero, o_neg, o_carry, o_ovf, o_err;

  alu_pipe #(.N_BITS(8), .N_OP(6)) dut (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b), .i_op(i_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_neg(o_neg), .o_carry(o_carry), .o_ovf(o_ovf), .o_err(o_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [12:0] e; int c; } ent_t;
  ent_t        q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [12:0] cur_exp;
  bit          last_acc;

  localparam logic [5:0] OPS [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
    6'b100110, 6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011};

  // {err, ovf, carry, neg, zero, result[7:0]}
  function automatic logic [12:0] model(logic [5:0] op, logic [7:0] a, logic [7:0] b);
    int ua = a, ub = b, sa = $signed(a), sb = $signed(b), r = 0, p;
    bit c = 0, v = 0, e = 0;
    logic [7:0] res;
    p = 1 << (ub < 8 ? ub : 0);
    case (op)
      6'b100000: begin r = ua + ub; c = r > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      6'b100010: begin r = ua - ub; c = ua < ub; v = (sa - sb > 127) || (sa - sb < -128); end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b101010: r = (sa < sb) ? 1 : 0;
      6'b000000: r = (ub >= 8) ? 0 : ua * p;
      6'b000010: r = (ub >= 8) ? 0 : ua / p;
      6'b000011: if (ub >= 8) r = (sa < 0) ? -1 : 0;
                 else r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      default: e = 1;
    endcase
    res = r[7:0];
    return {e, v, c, res[7], res == 8'h00, res};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    i_op = op; i_a = a; i_b = b;
    cur_exp = model(op, a, b);
  endtask

  // one clock: check outputs at negedge, update model, return 1ns after posedge
  task automatic cycle();
    bit vis, exp_rdy, emit, acc;
    @(negedge clock);
    vis     = (q.size() != 0) && (cyc >= q[0].c + 2);
    exp_rdy = !(q.size() == 2 && !i_ready);
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    chk("o_valid", 32'(o_valid), 32'(vis));
    if (vis) chk("out", 32'({o_err, o_ovf, o_carry, o_neg, o_zero, o_result}), 32'(q[0].e));
    emit = vis && i_ready;
    acc  = i_valid && exp_rdy;
    if (emit) void'(q.pop_front());
    if (acc) q.push_back('{cur_exp, cyc});
    last_acc = acc;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (q.size() != 0 && guard < 50) begin cycle(); guard++; end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  typedef struct { logic [5:0] op; logic [7:0] a, b; logic [12:0] e; } vec_t;
  vec_t dir [12] = '{
    '{6'b100000, 8'h7F, 8'h01, {5'b01010, 8'h80}},
    '{6'b100000, 8'hFF, 8'h01, {5'b00101, 8'h00}},
    '{6'b100010, 8'h00, 8'h01, {5'b00110, 8'hFF}},
    '{6'b100010, 8'h80, 8'h01, {5'b01000, 8'h7F}},
    '{6'b000011, 8'h80, 8'h03, {5'b00010, 8'hF0}},
    '{6'b000010, 8'h80, 8'h03, {5'b00000, 8'h10}},
    '{6'b000000, 8'h01, 8'h07, {5'b00010, 8'h80}},
    '{6'b000010, 8'h80, 8'h09, {5'b00001, 8'h00}},
    '{6'b000011, 8'h80, 8'h09, {5'b00010, 8'hFF}},
    '{6'b101010, 8'hFF, 8'h01, {5'b00000, 8'h01}},
    '{6'b101010, 8'h01, 8'hFF, {5'b00001, 8'h00}},
    '{6'b111111, 8'h12, 8'h34, {5'b10001, 8'h00}}
  };

  initial begin
    reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_a = '0; i_b = '0; i_op = '0; cur_exp = '0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_out", 32'({o_err, o_ovf, o_carry, o_neg, o_zero, o_result}), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // single ADD: invisible one cycle after accept, visible the next
    set_in(dir[0].op, dir[0].a, dir[0].b);
    cur_exp = dir[0].e;
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    cycle();
    cycle();
    drain();

    // directed table, back-to-back, constant expectations
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_in(dir[i].op, dir[i].a, dir[i].b);
      cur_exp = dir[i].e;
      i_valid = 1'b1;
      cycle();
    end
    drain();

    // stream of 6 with the sink always ready
    for (int i = 0; i < 6; i++) begin
      set_in(OPS[$urandom_range(9)], 8'($urandom), 8'($urandom_range(9)));
      i_valid = 1'b1;
      cycle();
    end
    drain();

    // stream of 6 with the sink stalled for cycles 3..6
    begin
      int sent = 0;
      set_in(OPS[$urandom_range(9)], 8'($urandom), 8'($urandom_range(9)));
      for (int t = 0; t < 14; t++) begin
        i_valid = (sent < 6);
        i_ready = !(t >= 3 && t <= 6);
        cycle();
        if (last_acc) begin
          sent++;
          set_in(OPS[$urandom_range(9)], 8'($urandom), 8'($urandom_range(9)));
        end
      end
      chk("bp_sent", 32'(sent), 32'd6);
      drain();
    end

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      logic [5:0] op;
      op = ($urandom_range(7) == 0) ? 6'($urandom) : OPS[$urandom_range(9)];
      set_in(op, 8'($urandom), ($urandom_range(1) != 0) ? 8'($urandom_range(11)) : 8'($urandom));
      i_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(9) < 7);
      cycle();
    end
    drain();

    // fill both stages, then reset off-edge
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(OPS[$urandom_range(9)], 8'($urandom), 8'($urandom_range(9)));
      cycle();
    end
    i_valid = 1'b0;
    chk("full_ready", 32'(o_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_out", 32'({o_err, o_ovf, o_carry, o_neg, o_zero, o_result}), 32'd0);
    q.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    i_ready = 1'b1;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
